// File: rtl/modinv_pkg.sv
// Shared types and constants for the binary modular inverse engine.
package modinv_pkg;

    // Watchdog default: MAX_CYCLES = MODINV_CYC_FACTOR * WIDTH + MODINV_CYC_EXTRA
    localparam int unsigned MODINV_CYC_FACTOR = 4;
    localparam int unsigned MODINV_CYC_EXTRA  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHECK   = 2'd1,
        ITERATE = 2'd2,
        DONE    = 2'd3
    } modinv_state_e;

endpackage

// File: rtl/modhalf_sub.sv
// Combinational update for one Bezout coefficient register: either a modular
// halving (x/2 mod base) or a modular subtraction (x - y mod base).
// Operands are assumed already reduced into [0, base-1].
module modhalf_sub #(
    parameter int unsigned WIDTH = 512
) (
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  logic [WIDTH-1:0] i_base,
    input  logic             i_half,
    output logic [WIDTH-1:0] o_x
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_half_wide;
    logic [WIDTH-1:0] w_diff;
    logic             w_unused_lsb;

    // x + base can carry out of WIDTH bits, so keep the extra bit before halving
    assign w_sum        = {1'b0, i_x} + {1'b0, i_base};
    assign w_half_wide  = i_x[0] ? w_sum : {1'b0, i_x};
    // Bit 0 of the even value is dropped by the shift
    assign w_unused_lsb = w_half_wide[0];

    // Wraps modulo 2^WIDTH; adding base back lands in [0, base-1]
    assign w_diff = i_x - i_y;

    // Select halving or modular subtraction
    always_comb begin
        o_x = '0;
        if (i_half) begin
            o_x = w_half_wide[WIDTH:1];
        end else if (i_x >= i_y) begin
            o_x = w_diff;
        end else begin
            o_x = w_diff + i_base;
        end
    end

endmodule

// File: rtl/modular_inverse_bin.sv
// Modular inverse b = a^-1 mod base using the binary extended Euclid
// algorithm: one shift or subtract step per cycle, no multiplier/divider.
module modular_inverse_bin
    import modinv_pkg::*;
#(
    parameter int unsigned WIDTH      = 512,
    parameter int unsigned MAX_CYCLES = MODINV_CYC_FACTOR * WIDTH + MODINV_CYC_EXTRA
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] base,
    input  logic             valid_in,
    input  logic             abort_in,
    output logic [WIDTH-1:0] b_out,
    output logic             valid_out,
    output logic             error_out,
    output logic             busy_out
);

    localparam int unsigned CntW = $clog2(MAX_CYCLES + 1);

    modinv_state_e    r_state, w_state_d;
    logic [WIDTH-1:0] r_u, w_u_d;
    logic [WIDTH-1:0] r_v, w_v_d;
    logic [WIDTH-1:0] r_x1, w_x1_d;
    logic [WIDTH-1:0] r_x2, w_x2_d;
    logic [WIDTH-1:0] r_base, w_base_d;
    logic [WIDTH-1:0] r_b, w_b_d;
    logic             r_err, w_err_d;
    logic [CntW-1:0]  r_cnt, w_cnt_d;

    logic             w_u_even;
    logic             w_v_even;
    logic [WIDTH-1:0] w_x1_new;
    logic [WIDTH-1:0] w_x2_new;

    assign w_u_even = ~r_u[0];
    assign w_v_even = ~r_v[0];

    // x1 tracks u (x1*a == u mod base); halves with u, else subtracts x2
    modhalf_sub #(
        .WIDTH (WIDTH)
    ) u_x1_path (
        .i_x    (r_x1),
        .i_y    (r_x2),
        .i_base (r_base),
        .i_half (w_u_even),
        .o_x    (w_x1_new)
    );

    // x2 tracks v (x2*a == v mod base); halves with v, else subtracts x1
    modhalf_sub #(
        .WIDTH (WIDTH)
    ) u_x2_path (
        .i_x    (r_x2),
        .i_y    (r_x1),
        .i_base (r_base),
        .i_half (w_v_even),
        .o_x    (w_x2_new)
    );

    // Next-state and datapath update
    always_comb begin
        w_state_d = r_state;
        w_u_d     = r_u;
        w_v_d     = r_v;
        w_x1_d    = r_x1;
        w_x2_d    = r_x2;
        w_base_d  = r_base;
        w_b_d     = r_b;
        w_err_d   = r_err;
        w_cnt_d   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (valid_in) begin
                    w_u_d     = a_in;
                    w_base_d  = base;
                    w_cnt_d   = '0;
                    w_state_d = CHECK;
                end
            end
            CHECK: begin
                if (abort_in) begin
                    w_state_d = IDLE;
                end else if (!r_base[0] || (r_base < WIDTH'(3)) || (r_u == '0) ||
                             (r_u >= r_base)) begin
                    w_b_d     = '0;
                    w_err_d   = 1'b1;
                    w_state_d = DONE;
                end else if (r_u == WIDTH'(1)) begin
                    w_b_d     = WIDTH'(1);
                    w_err_d   = 1'b0;
                    w_state_d = DONE;
                end else begin
                    w_v_d     = r_base;
                    w_x1_d    = WIDTH'(1);
                    w_x2_d    = '0;
                    w_cnt_d   = '0;
                    w_state_d = ITERATE;
                end
            end
            ITERATE: begin
                if (abort_in) begin
                    w_state_d = IDLE;
                end else if (r_u == WIDTH'(1)) begin
                    w_b_d     = r_x1;
                    w_err_d   = 1'b0;
                    w_state_d = DONE;
                end else if (r_v == WIDTH'(1)) begin
                    w_b_d     = r_x2;
                    w_err_d   = 1'b0;
                    w_state_d = DONE;
                end else if ((r_u == '0) || (r_v == '0) ||
                             (r_cnt == CntW'(MAX_CYCLES - 1))) begin
                    // gcd > 1, or the watchdog ran out
                    w_b_d     = '0;
                    w_err_d   = 1'b1;
                    w_state_d = DONE;
                end else begin
                    w_cnt_d = r_cnt + CntW'(1);
                    if (w_u_even) begin
                        w_u_d  = r_u >> 1;
                        w_x1_d = w_x1_new;
                    end else if (w_v_even) begin
                        w_v_d  = r_v >> 1;
                        w_x2_d = w_x2_new;
                    end else if (r_u >= r_v) begin
                        w_u_d  = r_u - r_v;
                        w_x1_d = w_x1_new;
                    end else begin
                        w_v_d  = r_v - r_u;
                        w_x2_d = w_x2_new;
                    end
                end
            end
            DONE: begin
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state <= IDLE;
            r_u     <= '0;
            r_v     <= '0;
            r_x1    <= '0;
            r_x2    <= '0;
            r_base  <= '0;
            r_b     <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_u     <= w_u_d;
            r_v     <= w_v_d;
            r_x1    <= w_x1_d;
            r_x2    <= w_x2_d;
            r_base  <= w_base_d;
            r_b     <= w_b_d;
            r_err   <= w_err_d;
            r_cnt   <= w_cnt_d;
        end
    end

    // Result registers only change on entry to DONE, so they hold afterwards
    assign b_out     = r_b;
    assign error_out = r_err;
    assign valid_out = (r_state == DONE);
    assign busy_out  = (r_state != IDLE);

endmodule

// File: tb/tb_modular_inverse_bin.sv
// Bench for modular_inverse_bin: directed WIDTH=16 cases plus WIDTH=64 random
// runs on parallel lanes, checked against an extended-Euclid reference model.
module tb_modular_inverse_bin;

    localparam int unsigned W16   = 16;
    localparam int unsigned M16   = 4 * W16 + 4;
    localparam int unsigned W64   = 64;
    localparam int unsigned M64   = 4 * W64 + 4;
    localparam int unsigned LANES = 8;
    localparam int unsigned RUNS  = 1000;

    typedef struct packed {
        logic [63:0] b;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 16-bit instance
    logic [W16-1:0] a16, base16, b16;
    logic           v_in16, abort16, v_out16, err16, busy16;

    modular_inverse_bin #(
        .WIDTH (W16)
    ) u_dut16 (
        .clk_in    (clk),
        .rst_n_in  (rst_n),
        .a_in      (a16),
        .base      (base16),
        .valid_in  (v_in16),
        .abort_in  (abort16),
        .b_out     (b16),
        .valid_out (v_out16),
        .error_out (err16),
        .busy_out  (busy16)
    );

    // 64-bit lanes
    logic [LANES-1:0][W64-1:0] a64, base64, b64;
    logic [LANES-1:0]          v_in64, v_out64, err64, busy64;
    logic                      abort64;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        modular_inverse_bin #(
            .WIDTH (W64)
        ) u_dut64 (
            .clk_in    (clk),
            .rst_n_in  (rst_n),
            .a_in      (a64[g]),
            .base      (base64[g]),
            .valid_in  (v_in64[g]),
            .abort_in  (abort64),
            .b_out     (b64[g]),
            .valid_out (v_out64[g]),
            .error_out (err64[g]),
            .busy_out  (busy64[g])
        );
    end

    int   total = 0;
    int   bad   = 0;
    exp_t q16[$];
    exp_t q64[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Classic extended Euclid with division; b = a^-1 mod m or err if gcd != 1
    function automatic void ref_inv(input logic [63:0] a, input logic [63:0] m,
                                    output logic [63:0] b, output logic err);
        logic [63:0]         r0, r1, q, rt;
        logic signed [131:0] t0, t1, tt;
        r0 = m;
        r1 = a;
        t0 = 0;
        t1 = 1;
        while (r1 != 64'd0) begin
            q  = r0 / r1;
            rt = r0 - q * r1;
            r0 = r1;
            r1 = rt;
            tt = t0 - $signed({68'd0, q}) * t1;
            t0 = t1;
            t1 = tt;
        end
        if (r0 != 64'd1) begin
            b   = '0;
            err = 1'b1;
        end else begin
            if (t0 < 0) t0 = t0 + $signed({68'd0, m});
            b   = t0[63:0];
            err = 1'b0;
        end
    endfunction

    function automatic logic [63:0] mulmod(input logic [63:0] a, input logic [63:0] b,
                                           input logic [63:0] m);
        logic [127:0] p;
        p = {64'd0, a} * {64'd0, b};
        p = p % {64'd0, m};
        return p[63:0];
    endfunction

    // One 16-bit request; exp_lat = 0 means only the upper latency bound applies
    task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] m,
                         input logic [15:0] exp_b, input logic exp_err, input int exp_lat);
        int   n;
        exp_t e;
        q16.push_back('{b: {48'd0, exp_b}, err: exp_err});
        a16    = a;
        base16 = m;
        v_in16 = 1'b1;
        tick();
        v_in16 = 1'b0;
        n = 1;
        check({tag, "/busy"}, busy16, 1);
        while (!v_out16 && n <= M16 + 3) begin
            tick();
            n++;
        end
        check({tag, "/valid"}, v_out16, 1);
        e = q16.pop_front();
        check({tag, "/b"}, b16, e.b);
        check({tag, "/err"}, err16, e.err);
        if (exp_lat != 0) check({tag, "/lat"}, n + 1, exp_lat);
        else check({tag, "/lat_bound"}, (n + 1 <= M16 + 3), 1);
        tick();
        check({tag, "/busy_drop"}, busy16, 0);
        check({tag, "/pulse_end"}, v_out16, 0);
        check({tag, "/b_hold"}, b16, e.b);
    endtask

    initial begin
        logic [63:0]      ra[LANES], rm[LANES], cb[LANES];
        logic [LANES-1:0] got, ce;
        logic [63:0]      a, m, eb;
        logic             ee;
        exp_t             e;
        int               n, seen;

        rst_n   = 1'b0;
        a16     = '0;
        base16  = '0;
        v_in16  = 1'b0;
        abort16 = 1'b0;
        a64     = '0;
        base64  = '0;
        v_in64  = '0;
        abort64 = 1'b0;
        tick();
        tick();
        check("rst/b", b16, 0);
        check("rst/valid", v_out16, 0);
        check("rst/err", err16, 0);
        check("rst/busy", busy16, 0);
        rst_n = 1'b1;
        tick();

        run16("inv3_7", 16'd3, 16'd7, 16'd5, 1'b0, 0);
        run16("inv17_3233", 16'd17, 16'd3233, 16'd2092, 1'b0, 0);
        run16("trivial_a1", 16'd1, 16'd7, 16'd1, 1'b0, 3);
        run16("gcd3", 16'd6, 16'd9, 16'd0, 1'b1, 0);
        run16("even_base", 16'd3, 16'd10, 16'd0, 1'b1, 3);
        run16("a_zero", 16'd0, 16'd7, 16'd0, 1'b1, 3);
        run16("a_ge_base", 16'd9, 16'd7, 16'd0, 1'b1, 3);
        run16("base_1", 16'd0, 16'd1, 16'd0, 1'b1, 3);
        run16("inv2_65535", 16'd2, 16'd65535, 16'd32768, 1'b0, 0);

        // Request during the valid_out cycle is dropped, accepted one cycle later
        a16    = 16'd1;
        base16 = 16'd7;
        v_in16 = 1'b1;
        tick();
        v_in16 = 1'b0;
        tick();
        check("done_cycle/valid", v_out16, 1);
        check("done_cycle/b", b16, 1);
        a16    = 16'd3;
        base16 = 16'd7;
        v_in16 = 1'b1;
        tick();
        check("done_cycle/ignored", busy16, 0);
        run16("after_done", 16'd3, 16'd7, 16'd5, 1'b0, 0);

        // Abort 5 cycles after acceptance
        a16    = 16'd17;
        base16 = 16'd3233;
        v_in16 = 1'b1;
        tick();
        v_in16 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("abort/busy_before", busy16, 1);
        abort16 = 1'b1;
        tick();
        abort16 = 1'b0;
        check("abort/busy", busy16, 0);
        check("abort/valid", v_out16, 0);
        seen = 0;
        for (int i = 0; i < M16 + 8; i++) begin
            if (v_out16) seen++;
            tick();
        end
        check("abort/no_pulse", seen, 0);
        run16("after_abort", 16'd3, 16'd7, 16'd5, 1'b0, 0);

        // Reset in the middle of ITERATE
        a16    = 16'd17;
        base16 = 16'd3233;
        v_in16 = 1'b1;
        tick();
        v_in16 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("midrst/busy_before", busy16, 1);
        rst_n = 1'b0;
        tick();
        check("midrst/b", b16, 0);
        check("midrst/valid", v_out16, 0);
        check("midrst/err", err16, 0);
        check("midrst/busy", busy16, 0);
        rst_n = 1'b1;
        seen  = 0;
        for (int i = 0; i < M16 + 8; i++) begin
            if (v_out16) seen++;
            tick();
        end
        check("midrst/no_pulse", seen, 0);

        // Random 64-bit runs, LANES requests in flight per round
        for (int r = 0; r < int'(RUNS / LANES); r++) begin
            for (int l = 0; l < int'(LANES); l++) begin
                m = {$urandom(), $urandom()} | 64'd1;
                if (m < 64'd3) m = 64'd3;
                a = {$urandom(), $urandom()} % m;
                ref_inv(a, m, eb, ee);
                q64.push_back('{b: eb, err: ee});
                ra[l]     = a;
                rm[l]     = m;
                a64[l]    = a;
                base64[l] = m;
            end
            v_in64 = '1;
            tick();
            v_in64 = '0;
            got = '0;
            ce  = '0;
            n   = 0;
            while (got != '1 && n < int'(M64) + 4) begin
                for (int l = 0; l < int'(LANES); l++) begin
                    if (v_out64[l] && !got[l]) begin
                        got[l] = 1'b1;
                        cb[l]  = b64[l];
                        ce[l]  = err64[l];
                    end
                end
                if (got != '1) begin
                    tick();
                    n++;
                end
            end
            for (int l = 0; l < int'(LANES); l++) begin
                e = q64.pop_front();
                check("rnd/done", got[l], 1);
                if (got[l]) begin
                    check("rnd/b", cb[l], e.b);
                    check("rnd/err", ce[l], e.err);
                    if (!e.err) check("rnd/prod", mulmod(ra[l], cb[l], rm[l]), 1);
                end
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/modular_inverse_bin.md
MODULAR_INVERSE_BIN -- requirements
Module: modular_inverse_bin

Interface
REQ-001 SHALL have parameter WIDTH, default 512, operand/result width in bits (legal range 8..4096).
REQ-002 SHALL have parameter MAX_CYCLES, default 4*WIDTH+4, watchdog bound on iteration cycles.
REQ-003 clk_in  input  1  sole clock, all state updates on rising edge.
REQ-004 rst_n_in  input  1  reset, synchronous, active-low.
REQ-005 a_in  input  WIDTH  value to invert, unsigned.
REQ-006 base  input  WIDTH  modulus, unsigned, must be odd and >= 3.
REQ-007 valid_in  input  1  request strobe, accepted only when busy_out=0.
REQ-008 abort_in  input  1  cancels an in-flight computation.
REQ-009 b_out  output  WIDTH  inverse b with a_in*b = 1 mod base, 0 <= b < base.
REQ-010 valid_out  output  1  one-cycle pulse, b_out/error_out valid.
REQ-011 error_out  output  1  qualified by valid_out; 1 = no inverse, illegal operands, or watchdog expiry.
REQ-012 busy_out  output  1  high from acceptance through the cycle valid_out pulses.

Function
REQ-013 SHALL use binary extended Euclid (shift/subtract only, no divider, no multiplier).
REQ-014 SHALL implement states IDLE, CHECK, ITERATE, DONE.
REQ-015 IDLE: on valid_in=1, latch a_in and base, set busy_out=1, go to CHECK next cycle.
REQ-016 IDLE: valid_in while busy_out=1 SHALL be ignored (no queuing).
REQ-017 CHECK (1 cycle): if base even, base<3, a=0, or a>=base -> DONE with error; if a=1 -> DONE with b=1; else init u=a, v=base, x1=1, x2=0, go ITERATE.
REQ-018 ITERATE SHALL perform exactly one step per cycle, priority order:
  - u even: u=u>>1; x1 = x1 even ? x1>>1 : (x1+base)>>1.
  - else v even: same on v, x2.
  - else u>=v: u=u-v; x1 = x1>=x2 ? x1-x2 : x1-x2+base.
  - else: v=v-u; x2 = x2>=x1 ? x2-x1 : x2-x1+base.
REQ-019 x1, x2 SHALL stay in [0, base-1] at all times; x+base SHALL be held in a WIDTH+1-bit intermediate.
REQ-020 ITERATE exit: u=1 -> result x1; v=1 -> result x2; u=0 or v=0 -> error (gcd>1); checked before the step each cycle, u=1 having priority over v=1.
REQ-021 Iteration counter SHALL force DONE with error when MAX_CYCLES steps elapse.
REQ-022 DONE (1 cycle): drive valid_out=1, b_out=result (0 on error), error_out; busy_out drops next cycle, return to IDLE.
REQ-023 Latency acceptance->valid_out SHALL be <= MAX_CYCLES+3 cycles; trivial/error cases exactly 3 cycles.
REQ-024 b_out and error_out SHALL hold their value until the next DONE.
REQ-025 abort_in=1 in CHECK or ITERATE SHALL go to IDLE next cycle with no valid_out pulse and busy_out=0; abort_in ignored in IDLE and DONE.
REQ-026 valid_in in the same cycle as valid_out SHALL be ignored; new request accepted from the following cycle.

Reset
REQ-027 rst_n_in=0 at a clock edge SHALL force IDLE, b_out=0, valid_out=0, error_out=0, busy_out=0, counter=0.
REQ-028 Reset mid-operation SHALL discard the computation with no valid_out pulse.

Structure
REQ-029 State enum (IDLE/CHECK/ITERATE/DONE) SHALL live in shared package modinv_pkg, with localparam for default MAX_CYCLES factor.
REQ-030 One sub-module SHALL be used: modhalf_sub, combinational half-step/modular-subtract datapath per x register, parameterised by WIDTH.
REQ-031 No divider instance SHALL be used.

Verification (WIDTH=16 unless noted)
REQ-032 a=3, base=7 -> valid_out after <=MAX_CYCLES+3 cycles, b_out=5, error_out=0.
REQ-033 a=17, base=3233 -> b_out=2092, error_out=0; a=1, base=7 -> b_out=1 in exactly 3 cycles.
REQ-034 a=6, base=9 -> error_out=1, b_out=0; base=10 -> error_out=1 in 3 cycles; a=0 -> error_out=1.
REQ-035 abort_in pulsed 5 cycles after acceptance of a=17, base=3233 -> no valid_out, busy_out=0 next cycle; new request a=3, base=7 then returns 5.
REQ-036 rst_n_in=0 mid-ITERATE -> all outputs 0 next cycle; random a<base, odd base, WIDTH=64 vs reference model, 1000 runs, all b_out match and a*b mod base = 1.
